branch_resolve_queue: RTL and testbench

BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

---
 rtl/branch_resolve_queue_pkg.sv | 27 ++
 rtl/branch_resolve_calc.sv | 35 +++
 rtl/branch_resolve_queue.sv | 136 +++++++++++++
 tb/tb_branch_resolve_queue.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_queue_pkg.sv
// rtl/branch_resolve_queue_pkg.sv - shared types for the branch resolve queue
package branch_resolve_queue_pkg;

  localparam int unsigned MAX_VLEN = 64;

  typedef enum logic [1:0] {
    CF_NONE   = 2'd0,
    CF_BRANCH = 2'd1,
    CF_JUMP   = 2'd2,
    CF_JUMPR  = 2'd3
  } cf_t;

  // Addresses are held at MAX_VLEN and sliced back to VLEN at the outputs.
  typedef struct packed {
    logic [MAX_VLEN-1:0] pc;
    logic [MAX_VLEN-1:0] target;
    logic                taken;
    logic                mispredict;
    logic                ex;
    cf_t                 cf;
  } brq_entry_t;

  function automatic logic target_misaligned(input logic [1:0] lsbs, input int unsigned rvc);
    return (rvc != 0) ? lsbs[0] : (|lsbs);
  endfunction

endpackage

// File: rtl/branch_resolve_calc.sv
// rtl/branch_resolve_calc.sv - per-port resolution of next PC, mispredict and
// misaligned-target exception (purely combinational)
module branch_resolve_calc
  import branch_resolve_queue_pkg::*;
#(
  parameter int unsigned VLEN = 64,
  parameter int unsigned RVC  = 1
) (
  input  logic [VLEN-1:0] pc_i,
  input  logic [VLEN-1:0] target_i,
  input  logic            taken_i,
  input  logic            is_compressed_i,
  input  logic            pred_taken_i,
  input  logic [VLEN-1:0] pred_target_i,
  input  logic [1:0]      cf_type_i,
  output brq_entry_t      entry_o
);

  logic [VLEN-1:0] seq_pc;

  assign seq_pc = pc_i + (is_compressed_i ? VLEN'(2) : VLEN'(4));

  // The exception tval equals the resolved target because ex implies taken.
  always_comb begin
    entry_o            = '0;
    entry_o.pc         = MAX_VLEN'(pc_i);
    entry_o.target     = MAX_VLEN'(taken_i ? target_i : seq_pc);
    entry_o.taken      = taken_i;
    entry_o.mispredict = (taken_i != pred_taken_i) ||
                         (taken_i && (target_i != pred_target_i));
    entry_o.ex         = taken_i && target_misaligned(target_i[1:0], RVC);
    entry_o.cf         = cf_t'(cf_type_i);
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - in-order queue of resolved branches with
// multi-port compacting enqueue and mispredict/exception squash on dequeue
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int unsigned VLEN     = 64,
  parameter int unsigned NR_PORTS = 2,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RVC      = 1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               flush_i,
  input  logic [NR_PORTS-1:0]                valid_i,
  input  logic [NR_PORTS-1:0][VLEN-1:0]      pc_i,
  input  logic [NR_PORTS-1:0][VLEN-1:0]      target_i,
  input  logic [NR_PORTS-1:0]                taken_i,
  input  logic [NR_PORTS-1:0]                is_compressed_i,
  input  logic [NR_PORTS-1:0]                pred_taken_i,
  input  logic [NR_PORTS-1:0][VLEN-1:0]      pred_target_i,
  input  logic [NR_PORTS-1:0][1:0]           cf_type_i,
  output logic                               ready_o,
  output logic                               res_valid_o,
  input  logic                               res_ready_i,
  output logic [VLEN-1:0]                    res_pc_o,
  output logic [VLEN-1:0]                    res_target_o,
  output logic                               res_taken_o,
  output logic                               res_mispredict_o,
  output logic [1:0]                         res_cf_o,
  output logic                               ex_valid_o,
  output logic [VLEN-1:0]                    ex_tval_o,
  output logic [$clog2(DEPTH):0]             count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  brq_entry_t      mem_q [DEPTH];
  brq_entry_t      new_entry [NR_PORTS];
  brq_entry_t      head;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   enq_cnt;
  logic [NR_PORTS-1:0] wr_en;
  logic [PW-1:0]   wr_idx [NR_PORTS];
  logic            not_empty;
  logic            deq;
  logic            kill;
  logic            enq_ok;

  for (genvar p = 0; p < NR_PORTS; p++) begin : g_calc
    branch_resolve_calc #(
      .VLEN (VLEN),
      .RVC  (RVC)
    ) u_calc (
      .pc_i            (pc_i[p]),
      .target_i        (target_i[p]),
      .taken_i         (taken_i[p]),
      .is_compressed_i (is_compressed_i[p]),
      .pred_taken_i    (pred_taken_i[p]),
      .pred_target_i   (pred_target_i[p]),
      .cf_type_i       (cf_type_i[p]),
      .entry_o         (new_entry[p])
    );
  end

  assign head      = mem_q[rd_ptr_q];
  assign not_empty = (count_q != '0);
  assign ready_o   = (count_q <= CW'(DEPTH - NR_PORTS));
  assign deq       = not_empty && res_ready_i;
  assign kill      = deq && (head.mispredict || head.ex);
  assign enq_ok    = ready_o && !flush_i && !kill;

  // Valid ports are packed into consecutive slots, lower port index first.
  always_comb begin
    enq_cnt = '0;
    wr_en   = '0;
    for (int i = 0; i < NR_PORTS; i++) begin
      wr_idx[i] = wr_ptr_q + enq_cnt[PW-1:0];
      wr_en[i]  = valid_i[i] && enq_ok;
      if (wr_en[i]) begin
        enq_cnt = enq_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q + enq_cnt[PW-1:0];
    count_d  = count_q + enq_cnt - CW'(deq);
    if (deq) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (kill) begin
      wr_ptr_d = rd_ptr_q + PW'(1);
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: every head output is gated by a non-zero count.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NR_PORTS; i++) begin
      if (wr_en[i]) begin
        mem_q[wr_idx[i]] <= new_entry[i];
      end
    end
  end

  assign res_valid_o      = not_empty;
  assign res_pc_o         = not_empty ? head.pc[VLEN-1:0] : '0;
  assign res_target_o     = not_empty ? head.target[VLEN-1:0] : '0;
  assign res_taken_o      = not_empty && head.taken;
  assign res_mispredict_o = not_empty && head.mispredict;
  assign res_cf_o         = not_empty ? head.cf : CF_NONE;
  assign ex_valid_o       = not_empty && head.ex;
  assign ex_tval_o        = (not_empty && head.ex) ? head.target[VLEN-1:0] : '0;
  assign count_o          = count_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb/tb_branch_resolve_queue.sv - directed and random checks against a
// queue-based reference model
module tb_branch_resolve_queue;

  localparam int VLEN = 32;
  localparam int NP   = 2;
  localparam int DEP  = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] nxt;
    logic        taken;
    logic        mis;
    logic        ex;
    logic [1:0]  cf;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic [NP-1:0]        valid;
  logic [NP-1:0][31:0]  pc, target, pred_target;
  logic [NP-1:0]        taken, comp, pred_taken;
  logic [NP-1:0][1:0]   cf;
  logic                 ready, res_valid, res_ready;
  logic [31:0]          res_pc, res_target, ex_tval;
  logic                 res_taken, res_mis, ex_valid;
  logic [1:0]           res_cf;
  logic [2:0]           count;

  int   checks = 0;
  int   errors = 0;
  exp_t mq[$];

  always #5 clk = ~clk;

  branch_resolve_queue #(
    .VLEN(VLEN), .NR_PORTS(NP), .DEPTH(DEP), .RVC(0)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid),
    .pc_i(pc), .target_i(target), .taken_i(taken), .is_compressed_i(comp),
    .pred_taken_i(pred_taken), .pred_target_i(pred_target), .cf_type_i(cf),
    .ready_o(ready), .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_pc_o(res_pc), .res_target_o(res_target), .res_taken_o(res_taken),
    .res_mispredict_o(res_mis), .res_cf_o(res_cf), .ex_valid_o(ex_valid),
    .ex_tval_o(ex_tval), .count_o(count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t resolve(input int p);
    exp_t e;
    e.pc    = pc[p];
    e.taken = taken[p];
    e.nxt   = taken[p] ? target[p] : pc[p] + (comp[p] ? 32'd2 : 32'd4);
    e.mis   = (taken[p] != pred_taken[p]) || (taken[p] && target[p] != pred_target[p]);
    e.ex    = taken[p] && (target[p][1:0] != 2'b00);
    e.cf    = cf[p];
    return e;
  endfunction

  task automatic tick();
    exp_t ne[$];
    int   sz   = mq.size();
    bit   rdy  = (DEP - sz) >= NP;
    bit   dq   = (sz > 0) && res_ready;
    bit   kl   = dq && (mq[0].mis || mq[0].ex);
    for (int p = 0; p < NP; p++)
      if (valid[p]) ne.push_back(resolve(p));
    @(posedge clk);
    #1;
    if (flush) mq.delete();
    else begin
      if (dq) void'(mq.pop_front());
      if (kl) mq.delete();
      else if (rdy) foreach (ne[k]) mq.push_back(ne[k]);
    end
  endtask

  task automatic check();
    int sz = mq.size();
    chk("count", 64'(count), 64'(sz));
    chk("ready", 64'(ready), 64'((DEP - sz) >= NP));
    chk("res_valid", 64'(res_valid), 64'(sz > 0));
    if (sz > 0) begin
      chk("res_pc", 64'(res_pc), 64'(mq[0].pc));
      chk("res_target", 64'(res_target), 64'(mq[0].nxt));
      chk("res_taken", 64'(res_taken), 64'(mq[0].taken));
      chk("res_mispredict", 64'(res_mis), 64'(mq[0].mis));
      chk("res_cf", 64'(res_cf), 64'(mq[0].cf));
      chk("ex_valid", 64'(ex_valid), 64'(mq[0].ex));
      if (mq[0].ex) chk("ex_tval", 64'(ex_tval), 64'(mq[0].nxt));
    end else begin
      chk("ex_valid_empty", 64'(ex_valid), 64'(0));
    end
  endtask

  task automatic set_port(input int p, input logic [31:0] pcv, input logic [31:0] tgt,
                          input logic tk, input logic cm, input logic ptk,
                          input logic [31:0] ptg, input logic [1:0] c);
    valid[p] = 1'b1; pc[p] = pcv; target[p] = tgt; taken[p] = tk; comp[p] = cm;
    pred_taken[p] = ptk; pred_target[p] = ptg; cf[p] = c;
  endtask

  task automatic good_port(input int p);
    set_port(p, $urandom & 32'hFFFF_FFFC, $urandom, 1'b0, 1'b0, 1'b0, 32'h0, 2'd1);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; res_ready = 1'b0; valid = '0;
    pc = '0; target = '0; pred_target = '0; taken = '0; comp = '0;
    pred_taken = '0; cf = '0;
    #3;
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_ready", 64'(ready), 64'(1));
    chk("rst_res_pc", 64'(res_pc), 64'(0));
    chk("rst_ex_valid", 64'(ex_valid), 64'(0));
    @(posedge clk); #1; rst = 1'b0;

    // two ports in order, second compressed and not taken
    set_port(0, 32'h100, 32'h200, 1'b1, 1'b0, 1'b1, 32'h200, 2'd1);
    set_port(1, 32'h104, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0,   2'd1);
    tick(); check();
    chk("order_t0", 64'(res_target), 64'(32'h200));
    chk("order_m0", 64'(res_mis), 64'(0));
    valid = '0; res_ready = 1'b1;
    tick(); check();
    chk("order_t1", 64'(res_target), 64'(32'h106));
    tick(); check();
    res_ready = 1'b0;

    // full threshold and dropped enqueue while not ready
    good_port(0); good_port(1); tick(); check();
    valid = '0; good_port(0); tick(); check();
    chk("full_ready", 64'(ready), 64'(0));
    good_port(0); good_port(1); tick(); check();
    chk("drop_count", 64'(count), 64'(3));
    valid = '0; res_ready = 1'b1; tick(); check();
    chk("deq_ready", 64'(ready), 64'(1));
    tick(); check(); tick(); check();
    res_ready = 1'b0;

    // mispredicted head squashes younger entries and a same-cycle enqueue
    set_port(0, 32'h40, 32'h80, 1'b1, 1'b0, 1'b0, 32'h0, 2'd1);
    good_port(1); tick(); check();
    valid = '0; good_port(0); tick(); check();
    chk("mis_head", 64'(res_mis), 64'(1));
    res_ready = 1'b1; good_port(0); tick(); check();
    chk("mis_count", 64'(count), 64'(0));
    valid = '0; res_ready = 1'b0; tick(); check();

    // misaligned taken target with RVC disabled
    set_port(0, 32'h1000, 32'h1002, 1'b1, 1'b0, 1'b1, 32'h1002, 2'd2);
    tick(); check();
    chk("ex_valid_dir", 64'(ex_valid), 64'(1));
    chk("ex_tval_dir", 64'(ex_tval), 64'(32'h1002));
    valid = '0; good_port(1); res_ready = 1'b1; tick(); check();
    valid = '0; res_ready = 1'b0;

    // flush overrides enqueue and dequeue
    good_port(0); good_port(1); tick(); check();
    flush = 1'b1; res_ready = 1'b1; good_port(0); good_port(1); tick(); check();
    chk("flush_count", 64'(count), 64'(0));
    chk("flush_valid", 64'(res_valid), 64'(0));
    flush = 1'b0; valid = '0; res_ready = 1'b0;

    // asynchronous reset with three entries held
    good_port(0); good_port(1); tick(); valid = '0; good_port(0); tick(); check();
    valid = '0;
    #2 rst = 1'b1;
    #1 mq.delete();
    chk("arst_count", 64'(count), 64'(0));
    chk("arst_valid", 64'(res_valid), 64'(0));
    chk("arst_ready", 64'(ready), 64'(1));
    @(negedge clk); rst = 1'b0;
    good_port(0); tick(); check();
    chk("post_rst_count", 64'(count), 64'(1));
    valid = '0;

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      for (int p = 0; p < NP; p++) begin
        valid[p]  = $urandom_range(0, 1);
        pc[p]     = $urandom & 32'hFFFF_FFFE;
        comp[p]   = $urandom_range(0, 1);
        taken[p]  = $urandom_range(0, 1);
        target[p] = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 15) == 0) target[p][1:0] = 2'($urandom_range(1, 3));
        cf[p]          = 2'($urandom_range(0, 3));
        pred_taken[p]  = taken[p];
        pred_target[p] = taken[p] ? target[p] : $urandom;
        if ($urandom_range(0, 15) == 0) pred_taken[p] = ~taken[p];
        if ($urandom_range(0, 15) == 0) pred_target[p] = $urandom;
      end
      res_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      tick(); check();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
